// File: rtl/encoder_pkg.sv
// Shared definitions for the priority request encoder.
//   state_t : presentation FSM states
//     IDLE    - nothing presented; a winner is loaded when one is eligible
//     PRESENT - an index is held on data_out until the consumer acks it
package encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage : encoder_pkg

// File: rtl/priority_select.sv
// Fixed-priority selector.
// This module is purely combinational. It picks one set bit of a request vector
// and returns that bit's binary index.
//   Parameters:
//     WIDTH      - number of request bits (>= 2)
//     HIGH_FIRST - 1: the greatest set index wins; 0: the least set index wins
//   Ports:
//     req   (in,  WIDTH)     - request vector
//     index (out, OUT_WIDTH) - index of the winning bit (0 when nothing is set)
//     any   (out, 1)         - at least one request bit is set
module priority_select #(
    parameter int WIDTH      = 8,
    parameter bit HIGH_FIRST = 1'b1,
    localparam int OUT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    output logic [OUT_WIDTH-1:0] index,
    output logic                 any
);

    // The scan runs toward the winning end. The last match overwrites earlier
    // matches, so it is the one that survives. Only indices below WIDTH are
    // visited, so an out-of-range code cannot appear, even for widths that
    // are not a power of two.
    always_comb begin
        index = '0;
        any   = 1'b0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    index = OUT_WIDTH'(i);
                    any   = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    index = OUT_WIDTH'(i);
                    any   = 1'b1;
                end
            end
        end
    end

endmodule : priority_select

// File: rtl/priority_request_encoder.sv
// Registered priority request encoder.
// Request lines are latched into sticky pending flags. The flags are masked per
// channel, and one winner is presented under a valid/ack handshake.
//   Parameters:
//     WIDTH      - number of request channels (>= 2; need not be a power of two)
//     HIGH_FIRST - 1: the highest index wins; 0: the lowest index wins
//   Ports:
//     clk           (in)             - system clock, rising edge
//     reset         (in)             - synchronous, active-high reset
//     data_in       (in,  WIDTH)     - request lines, sampled every cycle
//     mask          (in,  WIDTH)     - 1 = channel eligible for selection
//     ack           (in)             - consumer accepts the presented index
//     valid         (out)            - data_out holds a presented request
//     data_out      (out, OUT_WIDTH) - binary index of the presented channel
//     pending       (out, WIDTH)     - sticky request flags
//     pending_count (out, CNT_WIDTH) - population count of pending
module priority_request_encoder
    import encoder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit HIGH_FIRST = 1'b1,
    localparam int OUT_WIDTH = $clog2(WIDTH),
    localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     mask,
    input  logic                 ack,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic [WIDTH-1:0]     pending,
    output logic [CNT_WIDTH-1:0] pending_count
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic [OUT_WIDTH-1:0] r_data_out;
    logic [OUT_WIDTH-1:0] w_data_out_next;
    logic [WIDTH-1:0]     r_pending;
    logic [WIDTH-1:0]     w_clr;
    logic [WIDTH-1:0]     w_eligible;
    logic [OUT_WIDTH-1:0] w_win_index;
    logic                 w_win_any;
    logic [CNT_WIDTH-1:0] w_count;

    assign w_eligible = r_pending & mask;

    priority_select #(
        .WIDTH      (WIDTH),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_select (
        .req   (w_eligible),
        .index (w_win_index),
        .any   (w_win_any)
    );

    // This is a one-hot clear of the presented channel. It fires only on an
    // accepted handshake. Because ack is qualified by r_valid, ack has no
    // effect while the FSM is idle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clr
            assign w_clr[gi] = r_valid && ack && (r_data_out == OUT_WIDTH'(gi));
        end
    endgenerate

    // Sticky flags. The OR with data_in comes after the clear, so a request
    // that is re-asserted on its own ack cycle stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_next;
            r_valid    <= w_valid_next;
            r_data_out <= w_data_out_next;
        end
    end

    // Selection looks only at the registered flags. A new request is
    // therefore presented one edge after it is latched. Leaving PRESENT through
    // IDLE creates the idle bubble after every ack.
    always_comb begin
        w_state_next    = r_state;
        w_valid_next    = r_valid;
        w_data_out_next = r_data_out;
        unique case (r_state)
            IDLE: begin
                w_valid_next = 1'b0;
                if (w_win_any) begin
                    w_state_next    = PRESENT;
                    w_valid_next    = 1'b1;
                    w_data_out_next = w_win_index;
                end
            end
            PRESENT: begin
                // The presented index stays held: a higher-priority arrival
                // does not preempt it, and it is not retracted when mask or
                // pending changes.
                if (ack) begin
                    w_state_next = IDLE;
                    w_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // The count is sized for WIDTH+1 values, so the all-pending case does not wrap.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + CNT_WIDTH'(r_pending[i]);
        end
    end

    assign valid         = r_valid;
    assign data_out      = r_data_out;
    assign pending       = r_pending;
    assign pending_count = w_count;

endmodule : priority_request_encoder

// File: doc/priority_request_encoder.md
Name: priority_request_encoder

Overview:
- Parametrised, registered successor to the combinational one-hot encoder.
- Latches request lines into sticky pending flags and masks them per channel.
- Selects one winner by fixed priority and presents its binary index under a valid/ack handshake.
- Sits between device/interrupt flag sources and the control unit, which consumes one request index at a time.

Parameters:
- WIDTH, 8, number of request channels; must be >= 2; non-power-of-two allowed.
- HIGH_FIRST, 1, 1 = highest index wins; 0 = lowest index wins.
- OUT_WIDTH, $clog2(WIDTH), derived localparam; width of the index output.
- CNT_WIDTH, $clog2(WIDTH+1), derived localparam; width of the pending count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  request lines; level-sampled every cycle.
- mask  input  WIDTH  per-channel enable; 1 = channel eligible for selection.
- ack  input  1  consumer accepts the presented index.
- valid  output  1  data_out holds a presented request.
- data_out  output  OUT_WIDTH  binary index of the presented channel.
- pending  output  WIDTH  registered sticky request flags.
- pending_count  output  CNT_WIDTH  population count of pending, combinational from the register.

Behaviour:
- Reset (synchronous, dominates all other inputs): pending=0, valid=0, data_out=0, state=IDLE. data_in is not latched during reset cycles.
- Pending update, every non-reset edge: pending <= (pending & ~clr) | data_in.
  - clr is one-hot at data_out when valid && ack; otherwise 0.
  - Set wins over clear: a request re-asserted on its own ack cycle stays pending.
- FSM states: IDLE, PRESENT.
  - IDLE: if any(pending & mask) at the edge, load data_out = winner(pending & mask), set valid=1, go to PRESENT. Otherwise hold valid=0; data_out keeps its last value.
  - PRESENT: data_out and valid are held stable while ack=0. No preemption by higher-priority arrivals. No retraction if mask or pending changes.
  - PRESENT with ack=1: clear that pending bit, set valid=0, go to IDLE.
  - ack is ignored in IDLE.
- Latency:
  - Request seen on data_in at edge t sets pending at edge t. valid rises at edge t+1 at the earliest.
  - After an ack there is one mandatory idle bubble cycle before the next valid.
- Winner selection:
  - HIGH_FIRST=1: greatest set index wins.
  - HIGH_FIRST=0: least set index wins.
  - An all-zero masked vector produces no presentation.
- Width rule: indices >= WIDTH never appear on data_out, including when WIDTH is not a power of two.
- pending_count ranges 0..WIDTH and is never truncated.
- Reset mid-PRESENT: valid=0 and pending=0 after the reset edge, regardless of ack.

Decomposition:
- Shared package encoder_pkg holds the state typedef (IDLE, PRESENT).
- Sub-module priority_select (params WIDTH, HIGH_FIRST):
  - purely combinational;
  - inputs: a request vector;
  - outputs: index (OUT_WIDTH) and any (1).
- The top module holds the pending register, the FSM and the popcount.

Test Plan (WIDTH=8 unless stated):
- Reset: hold reset=1 with data_in=8'hFF for 2 cycles -> valid=0, pending=0, pending_count=0. Release reset with data_in still 8'hFF -> pending=8'hFF after the first edge, valid=1 with data_out=7 after the next edge.
- Single request: one-cycle pulse data_in=8'h08, mask=8'hFF -> pending=8'h08, then valid=1 and data_out=3. ack=1 for one cycle -> valid=0, pending=0, pending_count=0.
- Priority order: pulse data_in=8'h24.
  - HIGH_FIRST=1 -> presents 5; ack; one bubble; then presents 2.
  - HIGH_FIRST=0 -> presents 2, then 5.
- Hold/no preemption: with HIGH_FIRST=0 and index 2 presented, pulse data_in=8'h01 -> data_out stays 2 for 5 cycles without ack. After ack and the bubble, data_out=0.
- Set-over-clear: index 3 presented; assert ack=1 and data_in=8'h08 in the same cycle -> pending[3]=1, valid=0 for one cycle, then valid=1 with data_out=3.
- Mask and mid-op reset:
  - pending=8'h81, mask=8'h7F -> data_out=0.
  - mask=0 -> valid stays 0, pending_count=2.
  - reset asserted while PRESENT -> valid=0, pending=0 on the next edge.
- Odd width: WIDTH=5, HIGH_FIRST=1, data_in=5'b10000 -> data_out=4 with OUT_WIDTH=3, pending_count=1.
